icdf_lut_arbiter: RTL

Round-robin arbiter that shares one ICDF lookup-table instance between N_REQ uniform-sample producers, e.g. several Sobol dimensions.
It selects one requester per cycle and drives that requester's 32-bit cdf onto the LUT input. An id tag travels through a latency-matched pipeline so each registered icdf result returns with the id of the requester that issued it.
It sits between the Sobol generators and the single ICDF_LUT instance.

---
 rtl/icdf_lut_arbiter_if.sv | 31 +++
 rtl/icdf_lut_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/icdf_lut_arbiter_if.sv
// Bundle of the arbiter's requester, LUT and response signals.
// The arbiter takes the slave side; whoever drives requesters and models the LUT takes master.
interface icdf_lut_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int CDF_W  = 32,
    parameter int ICDF_W = 13
);
    localparam int ID_W = $clog2(N_REQ);

    logic                    en;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*CDF_W-1:0]  req_cdf;
    logic [N_REQ-1:0]        req_ready;
    logic [CDF_W-1:0]        lut_cdf;
    logic [ICDF_W-1:0]       lut_icdf;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [ICDF_W-1:0]       rsp_icdf;
    logic [15:0]             issue_cnt;
    logic                    busy;

    modport slave (
        input  en, req_valid, req_cdf, lut_icdf,
        output req_ready, lut_cdf, rsp_valid, rsp_id, rsp_icdf, issue_cnt, busy
    );

    modport master (
        output en, req_valid, req_cdf, lut_icdf,
        input  req_ready, lut_cdf, rsp_valid, rsp_id, rsp_icdf, issue_cnt, busy
    );
endinterface

// File: rtl/icdf_lut_arbiter.sv
// Round-robin arbiter sharing one ICDF LUT between N_REQ sample producers.
// A tag pipeline matched to the LUT latency returns each result with its requester id.
module icdf_lut_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LUT_LAT = 1,
    parameter int CDF_W   = 32,
    parameter int ICDF_W  = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    icdf_lut_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int LAST = LUT_LAT - 1;

    logic [ID_W-1:0]    ptr_reg;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic [ID_W:0]      scan_idx;
    logic [CDF_W-1:0]   cdf_lane [N_REQ];

    logic [LUT_LAT-1:0] tag_valid_reg;
    logic [LUT_LAT-1:0] tag_valid_next;
    logic [ID_W-1:0]    tag_id_reg [LUT_LAT];

    logic               rsp_valid_reg;
    logic [ID_W-1:0]    rsp_id_reg;
    logic [ICDF_W-1:0]  rsp_icdf_reg;
    logic [15:0]        issue_cnt_reg;
    logic               busy_reg;

    // Slice the flat cdf bus into lanes and decode the one-hot grant.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign cdf_lane[gi]      = bus.req_cdf[gi*CDF_W +: CDF_W];
            assign bus.req_ready[gi] = grant_any && (grant_id == ID_W'(gi));
        end
    endgenerate

    // Scan from ptr upward (mod N_REQ); iterating backwards lets the nearest valid requester win.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(N_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(N_REQ);
            end
            if (bus.en && bus.req_valid[scan_idx[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx[ID_W-1:0];
            end
        end
    end

    assign bus.lut_cdf = grant_any ? cdf_lane[grant_id] : '0;

    // Valid bits as they will be after the next edge; busy looks one edge ahead with these.
    assign tag_valid_next[0] = grant_any;
    generate
        for (gi = 1; gi < LUT_LAT; gi++) begin : g_shift
            assign tag_valid_next[gi] = tag_valid_reg[gi-1];
        end
    endgenerate

    // Tag pipeline: stage 0 captures the current grant, later stages shift once per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_reg <= '0;
            for (int s = 0; s < LUT_LAT; s++) begin
                tag_id_reg[s] <= '0;
            end
        end else begin
            tag_valid_reg <= tag_valid_next;
            tag_id_reg[0] <= grant_id;
            for (int s = 1; s < LUT_LAT; s++) begin
                tag_id_reg[s] <= tag_id_reg[s-1];
            end
        end
    end

    // Round-robin pointer moves just past the requester that transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (grant_any) begin
            ptr_reg <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    // Response register: icdf is only captured when the matching tag arrives, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_icdf_reg  <= '0;
        end else begin
            rsp_valid_reg <= tag_valid_reg[LAST];
            rsp_id_reg    <= tag_id_reg[LAST];
            if (tag_valid_reg[LAST]) begin
                rsp_icdf_reg <= bus.lut_icdf;
            end
        end
    end

    // Accepted-sample counter (free-running wrap) and in-flight indicator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_reg <= '0;
            busy_reg      <= 1'b0;
        end else begin
            if (grant_any) begin
                issue_cnt_reg <= issue_cnt_reg + 16'd1;
            end
            busy_reg <= (|tag_valid_next) | tag_valid_reg[LAST];
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_icdf  = rsp_icdf_reg;
    assign bus.issue_cnt = issue_cnt_reg;
    assign bus.busy      = busy_reg;
endmodule
